// File: rtl/collatz_sched_if.sv
// Requester/kernel bundle for collatz_sched: job requests, responses and the kernel control lines.
// req_valid[i] with req_n slice i is held until req_ready[i] pulses (transfer in that cycle);
// dropping req_valid earlier withdraws the job; rsp_valid has no backpressure.
interface collatz_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_n;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_data;
   logic                 rsp_err;
   logic                 kern_rst_n;
   logic                 kern_start;
   logic [31:0]          kern_n;
   logic                 kern_finish;
   logic [31:0]          kern_ret;

   modport master (
      output req_valid, req_n, kern_finish, kern_ret,
      input  req_ready, rsp_valid, rsp_data, rsp_err, kern_rst_n, kern_start, kern_n
   );

   modport slave (
      input  req_valid, req_n, kern_finish, kern_ret,
      output req_ready, rsp_valid, rsp_data, rsp_err, kern_rst_n, kern_start, kern_n
   );
endinterface

// File: rtl/collatz_sched.sv
// Round-robin scheduler sharing one collatz kernel between NREQ requesters.
// Optional RUN watchdog enabled by defining COLLATZ_SCHED_TIMEOUT_EN.
module collatz_sched #(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   collatz_sched_if.slave       bus,
   output logic [1:0]           dbg_state
);

   localparam int IW = $clog2(NREQ);

   // Debug encoding: 0 IDLE, 1 KRST, 2 RUN, 3 RESP
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KRST = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand;
   logic            grant_any;
   logic            krst_cnt;
   logic            timeout_hit;
   logic [31:0]     sel_n;
   logic [31:0]     kern_n_q;
   logic [31:0]     rsp_data_q;

   // Scan from farthest to nearest so the requester right after last_grant wins.
   always_comb begin : rr_pick
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NREQ);
         for (int i = 0; i < NREQ; i++) begin
            if (cand == IW'(i) && bus.req_valid[i]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin : operand_mux
      sel_n = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IW'(i)) sel_n = bus.req_n[32*i +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin : next_state
      state_nx = state;
      case (state)
         IDLE:    if (grant_any) state_nx = KRST;
         KRST:    if (krst_cnt) state_nx = RUN;
         RUN:     if (bus.kern_finish || timeout_hit) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IW'(NREQ - 1);
         owner      <= '0;
         kern_n_q   <= '0;
         rsp_data_q <= '0;
         krst_cnt   <= 1'b0;
      end else begin
         krst_cnt <= (state == KRST) && !krst_cnt;
         if (state == IDLE && grant_any) begin
            kern_n_q   <= sel_n;
            owner      <= grant_idx;
            last_grant <= grant_idx;
         end
         // finish takes priority over a coincident timeout
         if (state == RUN) begin
            if (bus.kern_finish) rsp_data_q <= bus.kern_ret;
            else if (timeout_hit) rsp_data_q <= '0;
         end
      end
   end

`ifdef COLLATZ_SCHED_TIMEOUT_EN
   logic [31:0] run_cnt;
   logic        rsp_err_q;

   // Counter is zero in the first RUN cycle, so RESP follows TIMEOUT_CYCLES RUN cycles.
   assign timeout_hit = (run_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (state == RUN) run_cnt <= run_cnt + 32'd1;
         else              run_cnt <= '0;
         if (state == RUN) begin
            if (bus.kern_finish) rsp_err_q <= 1'b0;
            else if (timeout_hit) rsp_err_q <= 1'b1;
         end
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign timeout_hit    = 1'b0;
   assign bus.rsp_err    = 1'b0;
`endif

   always_comb begin : outputs
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_ready[i] = rst_n && (state == IDLE) && grant_any && (grant_idx == IW'(i));
         bus.rsp_valid[i] = (state == RESP) && (owner == IW'(i));
      end
   end

   // Kernel is held in reset everywhere except RUN.
   assign bus.kern_rst_n = (state == RUN);
   assign bus.kern_start = (state == RUN);
   assign bus.kern_n     = kern_n_q;
   assign bus.rsp_data   = rsp_data_q;
   assign dbg_state      = state;

endmodule
